// File: rtl/matvec_sequencer_pkg.sv
// Shared definitions for the matrix-vector sequencer: FSM state encoding and
// the element-slice helper used to unpack N*DW element buses.
package matvec_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_VEC = 2'd1,
      RUN      = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   // Upper bounds for the slice helper; callers zero-extend into these widths.
   localparam int MAX_BUS = 1024;
   localparam int MAX_DW  = 64;

   // Returns element idx (dw bits wide, element 0 in the LSBs) of a packed bus.
   function automatic logic [MAX_DW-1:0] elem_slice(
      input logic [MAX_BUS-1:0] bus,
      input int                 idx,
      input int                 dw
   );
      logic [MAX_BUS-1:0] shifted;
      logic [MAX_DW-1:0]  mask;
      shifted = bus >> (idx * dw);
      if (dw >= MAX_DW)
         mask = '1;
      else
         mask = (MAX_DW'(1) << dw) - MAX_DW'(1);
      return shifted[MAX_DW-1:0] & mask;
   endfunction

endpackage

// File: rtl/inner_product.sv
// Combinational dot product of two packed N-element vectors, unsigned,
// accumulated and truncated to DW bits (wrap-around arithmetic).
module inner_product
   import matvec_sequencer_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic [N*DW-1:0] inp1,
   input  logic [N*DW-1:0] inp2,
   output logic [DW-1:0]   result
);

   logic [MAX_DW-1:0] e1;
   logic [MAX_DW-1:0] e2;
   logic [2*DW-1:0]   prod;
   logic [DW-1:0]     acc;

   always_comb begin
      e1   = '0;
      e2   = '0;
      prod = '0;
      acc  = '0;
      for (int i = 0; i < N; i++) begin
         e1   = elem_slice(MAX_BUS'(inp1), i, DW);
         e2   = elem_slice(MAX_BUS'(inp2), i, DW);
         prod = e1[DW-1:0] * e2[DW-1:0];
         // Only the low DW bits of each product can affect the truncated sum.
         acc  = acc + prod[DW-1:0];
      end
      result = acc;
   end

endmodule

// File: rtl/matvec_sequencer.sv
// Computes y = A*x one row per cycle: latches x once per job, streams rows
// through inner_product and registers each result with its row index.
module matvec_sequencer
   import matvec_sequencer_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int RW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [RW-1:0]   cfg_rows,
   input  logic            vec_valid,
   output logic            vec_ready,
   input  logic [N*DW-1:0] vec_data,
   input  logic            row_valid,
   output logic            row_ready,
   input  logic [N*DW-1:0] row_data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [DW-1:0]   res_data,
   output logic [RW-1:0]   res_idx,
   output logic            res_last,
   output logic            busy,
   output logic            done
);

   // Every stream transfers on a rising edge where valid && ready; a source
   // holds its data stable while valid is high and ready is low.

   state_t          state;
   state_t          state_next;
   logic [RW-1:0]   rows_total;
   logic [RW-1:0]   row_cnt;
   logic [N*DW-1:0] vec_reg;
   logic [DW-1:0]   dot;
   logic            vec_fire;
   logic            row_fire;
   logic            res_fire;
   logic            last_row;
   logic            done_next;

   inner_product #(
      .N  (N),
      .DW (DW)
   ) u_inner_product (
      .inp1   (row_data),
      .inp2   (vec_reg),
      .result (dot)
   );

   assign vec_fire = vec_valid && vec_ready;
   assign row_fire = row_valid && row_ready;
   assign res_fire = res_valid && res_ready;
   assign last_row = (row_cnt == rows_total - RW'(1));
   assign busy     = (state != IDLE);

   always_comb begin
      state_next = state;
      vec_ready  = 1'b0;
      row_ready  = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_rows != '0)
                  state_next = LOAD_VEC;
               else
                  done_next = 1'b1;
            end
         end
         LOAD_VEC: begin
            vec_ready = 1'b1;
            if (vec_fire)
               state_next = RUN;
         end
         RUN: begin
            // Single output register: a row may enter whenever that slot frees.
            row_ready = !res_valid || res_ready;
            if (row_fire && last_row)
               state_next = FLUSH;
         end
         FLUSH: begin
            if (res_fire) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rows_total <= '0;
         row_cnt    <= '0;
         vec_reg    <= '0;
         done       <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
         if (state == IDLE && start && cfg_rows != '0) begin
            rows_total <= cfg_rows;
            row_cnt    <= '0;
         end
         if (vec_fire)
            vec_reg <= vec_data;
         if (row_fire)
            row_cnt <= row_cnt + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_idx   <= '0;
         res_last  <= 1'b0;
      end else if (row_fire) begin
         res_valid <= 1'b1;
         res_data  <= dot;
         res_idx   <= row_cnt;
         res_last  <= last_row;
      end else if (res_fire) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
- Sequences the combinational inner_product datapath to compute y = A·x: latches vector x once, then streams matrix rows through inner_product, one row per cycle.
- Registers each dot-product result with its row index and drives it out on a valid/ready result stream.
- Sits between the matrix/vector source (memory reader or test driver) and the result consumer. Single clock domain.

Parameters:
- N, 4, elements per row/vector (passed to inner_product as N)
- DW, 8, element width in bits (passed to inner_product as DW); result width is also DW
- RW, 8, width of the row-count and row-index fields

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle job start pulse, honoured only in IDLE
- cfg_rows  input  RW  number of matrix rows M for the job, sampled at start
- vec_valid  input  1  vector word valid
- vec_ready  output  1  vector accepted (high only in LOAD_VEC)
- vec_data  input  N*DW  vector x, element 0 in LSBs
- row_valid  input  1  matrix row valid
- row_ready  output  1  row accepted
- row_data  input  N*DW  matrix row, element 0 in LSBs
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_data  output  DW  dot product of row and x, modulo 2^DW
- res_idx  output  RW  row index of res_data, 0..M-1
- res_last  output  1  res_data belongs to row M-1
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset (async assert, sync deassert by the upstream reset logic): state=IDLE; vec_ready=0, row_ready=0, res_valid=0, res_data=0, res_idx=0, res_last=0, busy=0, done=0; row counter=0, vector register=0.
- Handshakes: a transfer occurs on an edge where valid&&ready. Data must hold while valid&&!ready. The block never drops or duplicates a row.
- IDLE:
  - start with cfg_rows!=0 -> latch M=cfg_rows, clear counter, go to LOAD_VEC.
  - start with cfg_rows==0 -> done=1 next cycle, stay in IDLE.
  - start while not in IDLE is ignored.
- LOAD_VEC: vec_ready=1. On vec handshake, latch vec_data and go to RUN.
- RUN:
  - row_ready = !res_valid || res_ready (single-stage output register, full throughput).
  - inner_product inputs: inp1=row_data, inp2=vector register.
  - On row handshake at edge k: after edge k, res_valid=1, res_data=inner_product result, res_idx=counter, res_last=(counter==M-1); counter increments.
  - On the same edge as the handshake with counter==M-1, go to FLUSH.
  - Latency row->result is 1 cycle. Back-to-back rows are accepted every cycle while res_ready=1.
- Output register: res_valid clears on a res handshake with no new row in the same cycle. With a simultaneous res handshake and row handshake, the register is overwritten and res_valid stays 1.
- FLUSH: row_ready=0. When the last result handshakes (res_valid&&res_ready), res_valid=0, done=1 on the following cycle, and go to IDLE.
- Arithmetic: sum of N products of DW-bit unsigned values, truncated to DW bits (wrap-around, no saturation), exactly as inner_product produces.
- The vector register holds x for the whole job. A new job requires a new vector load.
- Reset mid-job: all state is lost, outputs return to reset values immediately, and no done pulse is generated.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD_VEC, RUN, FLUSH) and the element-slice helper for packing N*DW buses.
- Sub-module: the existing inner_product instantiated once (N, DW passed through). All sequencing stays in matvec_sequencer.

Test Plan:
- N=4, DW=8: start with cfg_rows=2, vec={4,3,2,1} (elem0=1); rows {1,1,1,1} then {8,7,6,5}; res_ready=1 -> results 10 (idx 0) then 70 (idx 1, last=1) on consecutive cycles; done pulses one cycle after the last handshake.
- Wrap-around: vec all 0xFF, row all 0xFF, cfg_rows=1 -> res_data=0x04, res_last=1.
- Backpressure: cfg_rows=3 with res_ready low for 5 cycles after the first result -> row_ready=0 while res_valid held; res_data/res_idx stable; all 3 results delivered in order 0,1,2.
- Zero-row job and ignored start: cfg_rows=0 -> done pulse, busy stays 0, vec_ready never asserts; a start pulse during RUN changes nothing.
- Async reset mid-RUN after 1 of 3 rows -> all outputs 0 immediately. A following job with cfg_rows=1 completes correctly with idx 0.
